// File: rtl/pc_sequencer_pkg.sv
// pc_pkg: opcodes, pc_src encodings and flag indices shared by the PC unit
package pc_pkg;
  localparam logic [5:0] OP_BGT  = 6'b001000;
  localparam logic [5:0] OP_BLT  = 6'b001001;
  localparam logic [5:0] OP_BEQ  = 6'b001010;
  localparam logic [5:0] OP_BNE  = 6'b001011;
  localparam logic [5:0] OP_JMP  = 6'b001100;
  localparam logic [5:0] OP_CALL = 6'b001101;
  localparam logic [5:0] OP_RET  = 6'b001110;
  localparam logic [1:0] PCS_JUMP = 2'b00;
  localparam logic [1:0] PCS_SEQ  = 2'b01;
  localparam logic [1:0] PCS_BR   = 2'b10;
  localparam logic [1:0] PCS_RET  = 2'b11;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: return-address LIFO with full/empty status and overflow/underflow pulses
// ports: clk, reset (async high), push/pop requests, din pushed value,
//        top combinational top-of-stack, full/empty status, ovf/unf rejected-request pulses
module ras_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf
);
  localparam int AW   = $clog2(DEPTH);
  localparam int SP_W = AW + 1;
  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp;
  logic [AW-1:0]   top_idx;
  assign empty   = sp == '0;
  assign full    = sp == SP_W'(DEPTH);
  assign ovf     = push && full;
  assign unf     = pop && empty;
  assign top_idx = AW'(sp - 1'b1);
  assign top     = mem[top_idx];
  always_ff @(posedge clk or posedge reset)
    if (reset) sp <= '0;
    else if (push && !full) sp <= sp + 1'b1;
    else if (pop && !empty) sp <= sp - 1'b1;
  // storage is deliberately left unreset
  always_ff @(posedge clk)
    if (push && !full) mem[sp[AW-1:0]] <= din;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with branch/jump/call/return next-PC selection
// ports: clk, reset (async high), pc_we update strobe, op/flags/br_off/jmp_tgt decode inputs,
//        err_clr clears stack_err; pc, pc_src, stack_empty/full/err status outputs
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          PC_W        = 16,
  parameter int          OFF_W       = 12,
  parameter int          STACK_DEPTH = 8,
  parameter int          PC_INC      = 1,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_we,
  input  logic [5:0]       op,
  input  logic [2:0]       flags,
  input  logic [OFF_W-1:0] br_off,
  input  logic [PC_W-1:0]  jmp_tgt,
  input  logic             err_clr,
  output logic [PC_W-1:0]  pc,
  output logic [1:0]       pc_src,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);
  logic            taken, push, pop, ovf, unf;
  logic [PC_W-1:0] seq, br, top, next_pc;
  assign taken = (op == OP_BGT && !flags[FLAG_C] && !flags[FLAG_V]) ||
                 (op == OP_BLT && flags[FLAG_C]) ||
                 (op == OP_BEQ && flags[FLAG_Z]) ||
                 (op == OP_BNE && !flags[FLAG_Z]);
  assign pc_src = taken ? PCS_BR :
                  (op == OP_JMP || op == OP_CALL) ? PCS_JUMP :
                  op == OP_RET ? PCS_RET : PCS_SEQ;
  assign seq  = pc + PC_W'(PC_INC);
  assign br   = pc + PC_W'($signed(br_off));
  assign push = pc_we && op == OP_CALL;
  assign pop  = pc_we && pc_src == PCS_RET;
  // a return with nothing on the stack falls through sequentially
  assign next_pc = pc_src == PCS_BR ? br :
                   pc_src == PCS_JUMP ? jmp_tgt :
                   pc_src == PCS_RET ? (stack_empty ? seq : top) : seq;
  ras_stack #(.W(PC_W), .DEPTH(STACK_DEPTH)) u_ras (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(seq),
    .top(top), .full(stack_full), .empty(stack_empty), .ovf(ovf), .unf(unf)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= PC_W'(RESET_PC);
    else if (pc_we) pc <= next_pc;
  // a fresh error outranks a simultaneous clear
  always_ff @(posedge clk or posedge reset)
    if (reset) stack_err <= 1'b0;
    else if (ovf || unf) stack_err <= 1'b1;
    else if (err_clr) stack_err <= 1'b0;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table, directed and random checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;
  localparam logic [5:0] ADD = 6'b000000, BGT = 6'b001000, BLT = 6'b001001, BEQ = 6'b001010,
                         BNE = 6'b001011, JMP = 6'b001100, CALL = 6'b001101, RET = 6'b001110;
  logic        clk = 0, reset = 0, pc_we = 0, err_clr = 0;
  logic [5:0]  op = 0;
  logic [2:0]  flags = 0;
  logic [11:0] br_off = 0;
  logic [15:0] jmp_tgt = 0, pc;
  logic [1:0]  pc_src;
  logic        stack_empty, stack_full, stack_err;
  int passed = 0, total = 0;
  logic [15:0] m_pc;
  logic [15:0] m_st[$];
  logic        m_err;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_we(pc_we), .op(op), .flags(flags), .br_off(br_off),
    .jmp_tgt(jmp_tgt), .err_clr(err_clr), .pc(pc), .pc_src(pc_src),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [2:0] fl;
    logic [1:0] src;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h expected %h", nm, a, e);
    else passed++;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    m_st.delete();
    m_err = 1'b0;
  endtask

  task automatic chk_state();
    chk("pc", {16'h0, pc}, {16'h0, m_pc});
    chk("stack_empty", {31'h0, stack_empty}, {31'h0, m_st.size() == 0});
    chk("stack_full", {31'h0, stack_full}, {31'h0, m_st.size() == 8});
    chk("stack_err", {31'h0, stack_err}, {31'h0, m_err});
  endtask

  // one instruction slot: drive, check pc_src, clock, advance model, check state
  task automatic cyc(input logic we, input logic [5:0] o, input logic [2:0] fl,
                     input logic [11:0] off, input logic [15:0] tgt, input logic clr);
    logic tk, er;
    logic [1:0] es;
    logic [15:0] np;
    op = o; flags = fl; br_off = off; jmp_tgt = tgt; err_clr = clr; pc_we = we;
    case (o)
      BGT: tk = !fl[1] && !fl[2];
      BLT: tk = fl[1];
      BEQ: tk = fl[0];
      BNE: tk = !fl[0];
      default: tk = 1'b0;
    endcase
    es = tk ? 2'b10 : (o == JMP || o == CALL) ? 2'b00 : (o == RET) ? 2'b11 : 2'b01;
    #1 chk("pc_src", {30'h0, pc_src}, {30'h0, es});
    er = 1'b0;
    np = m_pc + 16'd1;
    if (we) begin
      if (tk) np = m_pc + {{4{off[11]}}, off};
      else if (o == JMP) np = tgt;
      else if (o == CALL) begin
        np = tgt;
        if (m_st.size() == 8) er = 1'b1;
        else m_st.push_back(m_pc + 16'd1);
      end else if (o == RET) begin
        if (m_st.size() == 0) er = 1'b1;
        else np = m_st.pop_back();
      end
      m_pc = np;
    end
    m_err = er ? 1'b1 : clr ? 1'b0 : m_err;
    @(posedge clk);
    #1;
    pc_we = 0; err_clr = 0;
    chk_state();
  endtask

  initial begin
    tbl = '{
      '{BGT, 3'b000, 2'b10}, '{BGT, 3'b010, 2'b01}, '{BGT, 3'b100, 2'b01},
      '{BLT, 3'b010, 2'b10}, '{BLT, 3'b000, 2'b01}, '{BEQ, 3'b001, 2'b10},
      '{BEQ, 3'b000, 2'b01}, '{BNE, 3'b000, 2'b10}, '{BNE, 3'b001, 2'b01},
      '{JMP, 3'b111, 2'b00}, '{CALL, 3'b000, 2'b00}, '{RET, 3'b001, 2'b11},
      '{6'b111111, 3'b101, 2'b01}, '{ADD, 3'b000, 2'b01}
    };
    reset = 1;
    #12 reset = 0;
    model_reset();
    @(posedge clk); #1;
    chk_state();
    chk("reset_pc", {16'h0, pc}, 32'h0);
    chk("reset_empty", {31'h0, stack_empty}, 32'h1);

    // decode table with pc_we low: pc_src follows op/flags, pc holds
    foreach (tbl[i]) begin
      op = tbl[i].op; flags = tbl[i].fl; jmp_tgt = 16'h5555; br_off = 12'h7;
      #1 chk("tbl_src", {30'h0, pc_src}, {30'h0, tbl[i].src});
      @(posedge clk); #1;
      chk("tbl_hold", {16'h0, pc}, 32'h0);
    end

    for (int i = 1; i <= 3; i++) begin
      cyc(1, ADD, 3'b000, 12'h0, 16'h0, 0);
      chk("seq_pc", {16'h0, pc}, i);
      chk("seq_src", {30'h0, pc_src}, 32'h1);
    end

    cyc(1, JMP, 3'b000, 12'h0, 16'h0010, 0);
    cyc(1, BEQ, 3'b001, 12'hFFC, 16'h0, 0);
    chk("beq_taken", {16'h0, pc}, 32'h000C);
    cyc(1, BEQ, 3'b000, 12'hFFC, 16'h0, 0);
    chk("beq_not", {16'h0, pc}, 32'h000D);

    cyc(1, JMP, 3'b000, 12'h0, 16'h0020, 0);
    cyc(1, CALL, 3'b000, 12'h0, 16'h0100, 0);
    chk("call_pc", {16'h0, pc}, 32'h0100);
    chk("call_nonempty", {31'h0, stack_empty}, 32'h0);
    cyc(1, RET, 3'b000, 12'h0, 16'h0, 0);
    chk("ret_pc", {16'h0, pc}, 32'h0021);
    chk("ret_empty", {31'h0, stack_empty}, 32'h1);

    cyc(1, JMP, 3'b000, 12'h0, 16'h0040, 0);
    for (int i = 0; i < 8; i++) cyc(1, CALL, 3'b000, 12'h0, 16'((i + 1) * 256), 0);
    chk("nest_full", {31'h0, stack_full}, 32'h1);
    cyc(1, CALL, 3'b000, 12'h0, 16'h0200, 0);
    chk("ovf_pc", {16'h0, pc}, 32'h0200);
    chk("ovf_err", {31'h0, stack_err}, 32'h1);
    for (int k = 0; k < 8; k++) begin
      cyc(1, RET, 3'b000, 12'h0, 16'h0, 0);
      chk("lifo", {16'h0, pc}, (k == 7) ? 32'h0041 : 32'((7 - k) * 256 + 1));
    end
    cyc(0, ADD, 3'b000, 12'h0, 16'h0, 1);

    cyc(1, JMP, 3'b000, 12'h0, 16'h0030, 0);
    cyc(1, RET, 3'b000, 12'h0, 16'h0, 0);
    chk("unf_pc", {16'h0, pc}, 32'h0031);
    chk("unf_err", {31'h0, stack_err}, 32'h1);
    cyc(0, ADD, 3'b000, 12'h0, 16'h0, 1);
    chk("err_clr", {31'h0, stack_err}, 32'h0);
    cyc(1, RET, 3'b000, 12'h0, 16'h0, 1);
    chk("err_wins", {31'h0, stack_err}, 32'h1);

    cyc(1, JMP, 3'b000, 12'h0, 16'hFFFF, 0);
    cyc(1, ADD, 3'b000, 12'h0, 16'h0, 0);
    chk("wrap", {16'h0, pc}, 32'h0);
    cyc(1, CALL, 3'b000, 12'h0, 16'h0500, 0);
    cyc(1, CALL, 3'b000, 12'h0, 16'h0600, 0);
    pc_we = 1; op = JMP; jmp_tgt = 16'h0777;
    #2 reset = 1;
    #1;
    chk("async_pc", {16'h0, pc}, 32'h0);
    chk("async_empty", {31'h0, stack_empty}, 32'h1);
    chk("async_err", {31'h0, stack_err}, 32'h0);
    pc_we = 0;
    @(posedge clk); #2 reset = 0;
    model_reset();
    @(posedge clk); #1;
    chk_state();
    cyc(0, JMP, 3'b000, 12'h0, 16'h1234, 0);
    chk("we0_hold", {16'h0, pc}, 32'h0);

    for (int n = 0; n < 2000; n++) begin
      logic [5:0] o;
      int r;
      r = $urandom_range(0, 9);
      o = (r < 4) ? 6'(8 + r) : (r == 4) ? JMP : (r < 7) ? CALL : (r < 9) ? RET : 6'($urandom);
      cyc($urandom_range(0, 3) != 0, o, 3'($urandom), 12'($urandom), 16'($urandom),
          $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-generation program-counter unit for the multi-cycle processor. It owns the PC register, resolves the next PC from the current opcode and ALU flags (conditional branch, jump, call, return, sequential), and keeps a hardware return-address stack of parametrised depth for CALL/RET. It updates only when the main control FSM strobes pc_we, and exposes pc_src plus stack status for debug and exception logic.

Parameters:
PC_W, 16, width of PC, targets and stack entries
OFF_W, 12, width of the signed branch offset
STACK_DEPTH, 8, number of return-address entries (power of 2, >=2)
PC_INC, 1, sequential increment in address units
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pc_we  in  1  PC update strobe from control FSM (one cycle per instruction)
op  in  6  current opcode
flags  in  3  [0] zero, [1] carry, [2] overflow
br_off  in  OFF_W  signed branch offset, relative to current PC
jmp_tgt  in  PC_W  absolute target for JMP/CALL
err_clr  in  1  synchronous clear of stack_err
pc  out  PC_W  current program counter
pc_src  out  2  selected source: 00 jump/call, 01 sequential, 10 branch taken, 11 return
stack_empty  out  1  no return addresses held
stack_full  out  1  STACK_DEPTH entries held
stack_err  out  1  sticky overflow/underflow indicator

Behaviour:
- Reset, asynchronous: pc=RESET_PC, sp=0, stack_empty=1, stack_full=0, stack_err=0. Stack RAM contents are not reset. Reset mid-instruction discards any pending update.
- Branch-taken decode uses opcode constants:
  - BGT 001000: !C && !V
  - BLT 001001: C
  - BEQ 001010: Z
  - BNE 001011: !Z
  - JMP 001100
  - CALL 001101
  - RET 001110
  - Any other opcode is sequential.
- pc_src is combinational from op/flags, independent of pc_we. Priority: branch taken > JMP/CALL > RET > sequential.
- Next-PC arithmetic is modulo 2^PC_W; wrap-around is silent.
  - sequential: pc+PC_INC
  - branch: pc + sign_extend(br_off)
  - jump/call: jmp_tgt
  - return: top of stack
- Latency: on the rising edge with pc_we=1, pc loads next-PC and the stack updates. The new value is visible the following cycle. With pc_we=0, pc and the stack hold.
- CALL with pc_we: push pc+PC_INC at stack[sp], sp++.
  - If stack_full: no push, sp unchanged, stack_err<=1, jump still taken.
- RET with pc_we: sp--, pc<=stack[sp-1].
  - If stack_empty: pc<=pc+PC_INC, sp unchanged, stack_err<=1.
- An untaken conditional branch is sequential; the stack is untouched.
- sp is log2(STACK_DEPTH)+1 bits. stack_full=(sp==STACK_DEPTH), stack_empty=(sp==0); both are registered-consistent with sp.
- err_clr clears stack_err next edge. If err_clr and a new error occur in the same cycle, the error wins (stack_err=1).
- Read of the stack top is combinational from the stack array; no read latency.

Decomposition:
- Shared package pc_pkg: opcode constants (OP_BGT, OP_BLT, OP_BEQ, OP_BNE, OP_JMP, OP_CALL, OP_RET), pc_src encodings (PCS_JUMP=00, PCS_SEQ=01, PCS_BR=10, PCS_RET=11), flag bit indices.
- One sub-module, ras_stack: parametrised LIFO with push/pop, full/empty and overflow/underflow pulse outputs.
- Next-PC mux and branch decode stay in pc_sequencer.

Test Plan:
- Reset, then 3 pc_we pulses with op=ADD (000000) -> pc 0,1,2,3; pc_src=01; stack_empty=1.
- pc=0x0010, op=BEQ, flags=001, br_off=-4, pc_we -> pc=0x000C, pc_src=10. Repeat with flags=000 -> pc=0x000D.
- pc=0x0020, CALL jmp_tgt=0x0100 -> pc=0x0100, stack_empty=0. Then RET -> pc=0x0021, stack_empty=1.
- 8 nested CALLs -> stack_full=1. 9th CALL to 0x0200 -> pc=0x0200, stack_err=1. 8 RETs return addresses in LIFO order.
- RET on empty stack at pc=0x0030 -> pc=0x0031, stack_err=1. Then err_clr -> stack_err=0. err_clr together with another empty RET -> stack_err stays 1.
- Edge cases in one sequence:
  - pc=0xFFFF sequential -> pc=0x0000.
  - Assert reset asynchronously mid-cycle after 2 CALLs -> pc=0, stack_empty=1 immediately.
  - pc_we=0 with op=JMP -> pc holds while pc_src=00.
